// File: rtl/avalon_multichannel_timer.sv
// avalon_multichannel_timer: NUM_CH prescaled down-counters behind one 32-bit Avalon-MM slave.
// Each channel has one-shot/continuous mode, snapshot capture and interrupt enable.
// Optional macro TIMER_PULSE_OUT_EN adds the timeout_pulse output and CONTROL bit4 PULSE_INV.
module avalon_multichannel_timer #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
`ifdef TIMER_PULSE_OUT_EN
    output logic [NUM_CH-1:0] timeout_pulse,
`endif
    output logic              irq
);

    localparam int unsigned GLB_BASE = 4 * NUM_CH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    // Architectural state
    ch_state_e             r_state   [NUM_CH];
    logic [CNT_W-1:0]      r_cnt     [NUM_CH];
    logic [CNT_W-1:0]      r_period  [NUM_CH];
    logic [CNT_W-1:0]      r_snap    [NUM_CH];
    logic [NUM_CH-1:0]     r_to;
    logic [NUM_CH-1:0]     r_ito;
    logic [NUM_CH-1:0]     r_cont;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [31:0]           r_readdata;

    // Next-state values
    ch_state_e             w_state_nxt  [NUM_CH];
    logic [CNT_W-1:0]      w_cnt_nxt    [NUM_CH];
    logic [CNT_W-1:0]      w_period_nxt [NUM_CH];
    logic [CNT_W-1:0]      w_snap_nxt   [NUM_CH];
    logic [NUM_CH-1:0]     w_to_nxt;
    logic [NUM_CH-1:0]     w_ito_nxt;
    logic [NUM_CH-1:0]     w_cont_nxt;
    logic [PRESCALE_W-1:0] w_pcnt_nxt;
    logic [PRESCALE_W-1:0] w_prescale_nxt;
    logic [31:0]           w_rdata;

    // Decode and events
    logic                  w_wr;
    logic [31:0]           w_addr;
    logic                  w_presc_wr;
    logic                  w_tick;
    logic [NUM_CH-1:0]     w_ch_hit;
    logic [NUM_CH-1:0]     w_sts_wr;
    logic [NUM_CH-1:0]     w_ctl_wr;
    logic [NUM_CH-1:0]     w_per_wr;
    logic [NUM_CH-1:0]     w_snap_wr;
    logic [NUM_CH-1:0]     w_to_evt;
    logic [NUM_CH-1:0]     w_pending;
    logic                  w_unused;

`ifdef TIMER_PULSE_OUT_EN
    logic [NUM_CH-1:0]     r_inv;
    logic [NUM_CH-1:0]     w_inv_nxt;
    logic [NUM_CH-1:0]     r_pulse;
`endif

    assign w_wr      = chipselect & ~write_n;
    assign w_pending = r_to & r_ito;
    assign irq       = |w_pending;
    assign readdata  = r_readdata;
    // read strobe is informational only: readdata tracks address every cycle
    assign w_unused  = ^{1'b0, read_n, writedata};
`ifdef TIMER_PULSE_OUT_EN
    assign timeout_pulse = r_pulse;
`endif

    // Address decode into per-channel register write strobes
    always_comb begin
        w_addr     = 32'(address);
        w_presc_wr = w_wr && (w_addr == GLB_BASE + 1);
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_ch_hit[c]  = (w_addr < GLB_BASE) && ((w_addr >> 2) == c);
            w_sts_wr[c]  = w_wr && w_ch_hit[c] && (address[1:0] == 2'd0);
            w_ctl_wr[c]  = w_wr && w_ch_hit[c] && (address[1:0] == 2'd1);
            w_per_wr[c]  = w_wr && w_ch_hit[c] && (address[1:0] == 2'd2);
            w_snap_wr[c] = w_wr && w_ch_hit[c] && (address[1:0] == 2'd3);
        end
    end

    // Prescaler, channel state machines and register updates
    always_comb begin
        w_tick         = (r_pcnt == r_prescale);
        w_prescale_nxt = r_prescale;
        w_pcnt_nxt     = w_tick ? '0 : r_pcnt + PRESCALE_W'(1);
        w_to_nxt       = r_to;
        w_ito_nxt      = r_ito;
        w_cont_nxt     = r_cont;
        w_to_evt       = '0;
`ifdef TIMER_PULSE_OUT_EN
        w_inv_nxt      = r_inv;
`endif
        if (w_presc_wr) begin
            w_prescale_nxt = writedata[PRESCALE_W-1:0];
            w_pcnt_nxt     = '0;
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_state_nxt[c]  = r_state[c];
            w_cnt_nxt[c]    = r_cnt[c];
            w_period_nxt[c] = r_period[c];
            w_snap_nxt[c]   = r_snap[c];

            // a PERIOD write suppresses any timeout in the same cycle
            w_to_evt[c] = (r_state[c] == ST_RUN) && w_tick &&
                          (r_cnt[c] == '0) && !w_per_wr[c];

            if ((r_state[c] == ST_RUN) && w_tick) begin
                w_cnt_nxt[c] = (r_cnt[c] == '0) ? r_period[c] : r_cnt[c] - CNT_W'(1);
            end
            if (w_to_evt[c] && !r_cont[c]) begin
                w_state_nxt[c] = ST_IDLE;
            end

            // timeout beats a coincident STATUS clear
            if (w_to_evt[c]) begin
                w_to_nxt[c] = 1'b1;
            end else if (w_sts_wr[c]) begin
                w_to_nxt[c] = 1'b0;
            end

            // START wins over STOP and over a one-shot stop in the same cycle
            if (w_ctl_wr[c]) begin
                w_ito_nxt[c]  = writedata[0];
                w_cont_nxt[c] = writedata[1];
`ifdef TIMER_PULSE_OUT_EN
                w_inv_nxt[c]  = writedata[4];
`endif
                if (writedata[3]) begin
                    w_state_nxt[c] = ST_IDLE;
                end
                if (writedata[2]) begin
                    w_state_nxt[c] = ST_RUN;
                end
            end

            if (w_per_wr[c]) begin
                w_period_nxt[c] = writedata[CNT_W-1:0];
                w_cnt_nxt[c]    = writedata[CNT_W-1:0];
                w_state_nxt[c]  = ST_IDLE;
            end

            if (w_snap_wr[c]) begin
                w_snap_nxt[c] = r_cnt[c];
            end
        end
    end

    // Read mux; result is registered so readdata follows address by one cycle
    always_comb begin
        w_rdata = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_ch_hit[c]) begin
                case (address[1:0])
                    2'd0:    w_rdata = {30'd0, (r_state[c] == ST_RUN), r_to[c]};
`ifdef TIMER_PULSE_OUT_EN
                    2'd1:    w_rdata = {29'd0, r_inv[c], r_cont[c], r_ito[c]};
`else
                    2'd1:    w_rdata = {30'd0, r_cont[c], r_ito[c]};
`endif
                    2'd2:    w_rdata = 32'(r_period[c]);
                    default: w_rdata = 32'(r_snap[c]);
                endcase
            end
        end
        if (w_addr == GLB_BASE) begin
            w_rdata = 32'(w_pending);
        end
        if (w_addr == GLB_BASE + 1) begin
            w_rdata = 32'(r_prescale);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt     <= '0;
            r_prescale <= '0;
            r_to       <= '0;
            r_ito      <= '0;
            r_cont     <= '0;
            r_readdata <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_state[c]  <= ST_IDLE;
                r_cnt[c]    <= CNT_W'(1);
                r_period[c] <= CNT_W'(1);
                r_snap[c]   <= '0;
            end
        end else begin
            r_pcnt     <= w_pcnt_nxt;
            r_prescale <= w_prescale_nxt;
            r_to       <= w_to_nxt;
            r_ito      <= w_ito_nxt;
            r_cont     <= w_cont_nxt;
            r_readdata <= w_rdata;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_state[c]  <= w_state_nxt[c];
                r_cnt[c]    <= w_cnt_nxt[c];
                r_period[c] <= w_period_nxt[c];
                r_snap[c]   <= w_snap_nxt[c];
            end
        end
    end

`ifdef TIMER_PULSE_OUT_EN
    // Timeout pulse output, optionally inverted per channel
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inv   <= '0;
            r_pulse <= '0;
        end else begin
            r_inv   <= w_inv_nxt;
            r_pulse <= w_to_evt ^ r_inv;
        end
    end
`endif

endmodule
